intersection_scheduler: RTL and testbench

Top-level phase scheduler for the two-road intersection (highway HW, country road CR). Owns a single one-second prescaler and a 2-digit BCD countdown. Sequences both roads' lights through green/yellow/all-red phases and grants the country road only on a car-sensor or pedestrian request. Its colour and count outputs drive the light drivers and the 7-segment display directly.

---
 rtl/traffic_pkg.sv | 11 +
 rtl/intersection_scheduler_if.sv | 13 +
 rtl/bcd_down_counter.sv | 23 ++
 rtl/intersection_scheduler.sv | 82 ++++++++
 tb/tb_intersection_scheduler.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared colour codes, phase encoding and BCD helpers for the intersection
package traffic_pkg;
   localparam logic [2:0] GREEN  = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] RED    = 3'b001;
   typedef enum logic [2:0] {HW_GREEN, HW_YELLOW, RED1, CR_GREEN, CR_YELLOW, RED2} phase_t;
   typedef logic [7:0] bcd_t;
   function automatic bcd_t to_bcd(input int v);
      return bcd_t'(((v / 10) << 4) + (v % 10));
   endfunction
endpackage

// File: rtl/intersection_scheduler_if.sv
// intersection_scheduler_if: sensor inputs and light/display outputs; master is the scheduler side
interface intersection_scheduler_if;
   import traffic_pkg::*;
   logic car;
   logic ped_req;
   logic walk;
   logic [2:0] color_hw;
   logic [2:0] color_cr;
   logic [2:0] phase;
   bcd_t count;
   modport master (input car, ped_req, output color_hw, color_cr, count, phase, walk);
   modport slave (output car, ped_req, input color_hw, color_cr, count, phase, walk);
endinterface

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: 2-digit BCD countdown with load, decrement-enable and hold at 00
module bcd_down_counter
   import traffic_pkg::*;
#(
   parameter bcd_t RST_VAL = 8'h00
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  bcd_t load_val,
   input  logic dec,
   output bcd_t q,
   output logic is_01,
   output logic is_00
);
   assign is_00 = q == 8'h00;
   assign is_01 = q == 8'h01;
   // load wins over decrement; units borrow 0->9 from tens so no A-F code ever appears
   always_ff @(posedge clk or posedge rst)
      if (rst) q <= RST_VAL;
      else if (load) q <= load_val;
      else if (dec && !is_00) q <= (q[3:0] == 4'd0) ? {q[7:4] - 4'd1, 4'd9} : {q[7:4], q[3:0] - 4'd1};
endmodule

// File: rtl/intersection_scheduler.sv
// intersection_scheduler: two-road phase sequencer with 1 s prescaler and BCD countdown; PED_WALK_EN enables pedestrian walk logic
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter int TICK_DIV   = 1000,
   parameter int T_HW_MIN   = 30,
   parameter int T_CR_GREEN = 30,
   parameter int T_YELLOW   = 5,
   parameter int T_ALLRED   = 2
) (
   input logic clk,
   input logic rst,
   intersection_scheduler_if.master bus
);
   localparam int PW = $clog2(TICK_DIV);
   localparam bcd_t D_HW = to_bcd(T_HW_MIN);
   localparam bcd_t D_CR = to_bcd(T_CR_GREEN);
   localparam bcd_t D_Y  = to_bcd(T_YELLOW);
   localparam bcd_t D_AR = to_bcd(T_ALLRED);
   phase_t state, state_n;
   logic [PW-1:0] presc;
   logic [2:0] hw_c, cr_c;
   logic tick, req, load, dec, is_01, is_00;
   bcd_t load_val, count;
   assign tick = presc == PW'(TICK_DIV - 1);
   assign bus.color_hw = hw_c;
   assign bus.color_cr = cr_c;
   assign bus.count = count;
   assign bus.phase = state;
`ifdef PED_WALK_EN
   logic ped_pend, walk, enter_cr;
   assign req = bus.car | ped_pend;
   assign enter_cr = state_n == CR_GREEN && state != CR_GREEN;
   assign bus.walk = walk;
   // a request on the CR_GREEN entry edge counts as served; walk lives only within CR_GREEN
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ped_pend <= 1'b0;
         walk <= 1'b0;
      end else begin
         ped_pend <= enter_cr ? 1'b0 : ped_pend | bus.ped_req;
         walk <= enter_cr ? ped_pend : walk & (state_n == CR_GREEN);
      end
`else
   assign req = bus.car;
   assign bus.walk = 1'b0;
`endif
   // next phase: HW_GREEN leaves on request at the last second or at once when parked at 00
   always_comb begin
      state_n = state;
      dec = 1'b0;
      if (state == HW_GREEN && req && (is_00 || (tick && is_01))) state_n = HW_YELLOW;
      else if (state != HW_GREEN && tick && is_01) state_n = state == RED2 ? HW_GREEN : phase_t'(state + 3'd1);
      else dec = tick;
      load = state_n != state;
      load_val = state_n == HW_GREEN ? D_HW : state_n == CR_GREEN ? D_CR :
                 (state_n == HW_YELLOW || state_n == CR_YELLOW) ? D_Y : D_AR;
   end
   // phase register, prescaler restart on phase entry, and registered colour decode
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= HW_GREEN;
         presc <= '0;
         hw_c <= GREEN;
         cr_c <= RED;
      end else begin
         state <= state_n;
         presc <= (load || tick) ? '0 : presc + 1'b1;
         hw_c <= state_n == HW_GREEN ? GREEN : state_n == HW_YELLOW ? YELLOW : RED;
         cr_c <= state_n == CR_GREEN ? GREEN : state_n == CR_YELLOW ? YELLOW : RED;
      end
   bcd_down_counter #(.RST_VAL(D_HW)) u_cnt (
      .clk(clk),
      .rst(rst),
      .load(load),
      .load_val(load_val),
      .dec(dec),
      .q(count),
      .is_01(is_01),
      .is_00(is_00)
   );
endmodule

// File: tb/tb_intersection_scheduler.sv
// tb_intersection_scheduler: scoreboard bench; expected per-cycle outputs queued by stimulus, popped by monitor
module tb_intersection_scheduler;
   localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001;
`ifdef PED_WALK_EN
   localparam logic W = 1'b1;
`else
   localparam logic W = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_cmp = 0, n_bad = 0, n_cyc = 0, n_cr12 = 0;
   logic [17:0] q[$];
   always #5 clk = ~clk;
   intersection_scheduler_if bus ();
   intersection_scheduler_if bus2 ();
   assign bus2.car = bus.car;
   assign bus2.ped_req = bus.ped_req;
   intersection_scheduler #(.TICK_DIV(4), .T_HW_MIN(3), .T_CR_GREEN(4), .T_YELLOW(2), .T_ALLRED(1))
      dut (.clk(clk), .rst(rst), .bus(bus));
   intersection_scheduler #(.TICK_DIV(4), .T_HW_MIN(3), .T_CR_GREEN(12), .T_YELLOW(2), .T_ALLRED(1))
      dut2 (.clk(clk), .rst(rst), .bus(bus2));

   function automatic logic [7:0] bcd(input int c);
      return 8'(((c / 10) * 16) + (c % 10));
   endfunction

   task automatic hold(input int n, input logic [2:0] hw, input logic [2:0] cr, input logic [7:0] cnt,
                       input logic [2:0] ph, input logic wk);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         q.push_back({hw, cr, cnt, ph, wk});
      end
   endtask

   task automatic timed(input logic [2:0] hw, input logic [2:0] cr, input logic [2:0] ph, input int d, input logic wk);
      for (int c = d; c >= 1; c--) hold(4, hw, cr, bcd(c), ph, wk);
   endtask

   task automatic hw_green(input int n00);
      hold(4, G, R, 8'h03, 3'd0, 1'b0);
      hold(4, G, R, 8'h02, 3'd0, 1'b0);
      hold(4, G, R, 8'h01, 3'd0, 1'b0);
      hold(n00, G, R, 8'h00, 3'd0, 1'b0);
   endtask

   task automatic after_hw_yellow(input logic wk);
      timed(R, R, 3'd2, 1, 1'b0);
      timed(R, G, 3'd3, 4, wk);
      timed(R, Y, 3'd4, 2, 1'b0);
      timed(R, R, 3'd5, 1, 1'b0);
   endtask

   // main scoreboard monitor, sampled mid-cycle
   always @(negedge clk) begin
      logic [17:0] e, a;
      n_cyc++;
      if (q.size() != 0) begin
         e = q.pop_front();
         a = {bus.color_hw, bus.color_cr, bus.count, bus.phase, bus.walk};
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL cycle%0d: got hw=%b cr=%b cnt=%h ph=%0d walk=%b, want hw=%b cr=%b cnt=%h ph=%0d walk=%b",
                     n_cyc, a[17:15], a[14:12], a[11:4], a[3:1], a[0], e[17:15], e[14:12], e[11:4], e[3:1], e[0]);
         end
      end
   end

   // long-CR instance: every count change inside CR_GREEN must step 12,11,10,09..01
   int exp2 = 0;
   logic [7:0] last2 = 8'h00;
   logic [2:0] lastph2 = 3'd0;
   always @(negedge clk) begin
      if (bus2.phase == 3'd3 && (lastph2 != 3'd3 || bus2.count != last2)) begin
         exp2 = (lastph2 != 3'd3) ? 12 : exp2 - 1;
         n_cmp++;
         n_cr12++;
         if (bus2.count !== bcd(exp2)) begin
            n_bad++;
            $display("FAIL cr12_count: got %h want %h", bus2.count, bcd(exp2));
         end
      end
      last2 = bus2.count;
      lastph2 = bus2.phase;
   end

   initial begin
      bus.car = 1'b0;
      bus.ped_req = 1'b0;
      @(posedge clk);
      #1;
      q.push_back({G, R, 8'h03, 3'd0, 1'b0});
      @(negedge clk);
      #1;
      rst = 1'b0;
      // idle: count 03,02,01 then parks at 00
      hold(3, G, R, 8'h03, 3'd0, 1'b0);
      hold(4, G, R, 8'h02, 3'd0, 1'b0);
      hold(4, G, R, 8'h01, 3'd0, 1'b0);
      hold(29, G, R, 8'h00, 3'd0, 1'b0);
      // one-cycle car pulse at 00: yellow on the next edge
      bus.car = 1'b1;
      hold(1, Y, R, 8'h02, 3'd1, 1'b0);
      bus.car = 1'b0;
      hold(3, Y, R, 8'h02, 3'd1, 1'b0);
      hold(4, Y, R, 8'h01, 3'd1, 1'b0);
      after_hw_yellow(1'b0);
      hw_green(4);
      // pedestrian request while parked
      bus.ped_req = 1'b1;
      hold(1, G, R, 8'h00, 3'd0, 1'b0);
      bus.ped_req = 1'b0;
`ifdef PED_WALK_EN
      hold(1, G, R, 8'h00, 3'd0, 1'b0);
      timed(Y, R, 3'd1, 2, 1'b0);
      timed(R, R, 3'd2, 1, 1'b0);
      timed(R, G, 3'd3, 4, 1'b1);
      hold(2, R, Y, 8'h02, 3'd4, 1'b0);
      bus.ped_req = 1'b1;
      hold(1, R, Y, 8'h02, 3'd4, 1'b0);
      bus.ped_req = 1'b0;
      hold(1, R, Y, 8'h02, 3'd4, 1'b0);
      hold(4, R, Y, 8'h01, 3'd4, 1'b0);
      timed(R, R, 3'd5, 1, 1'b0);
      hw_green(0);
      timed(Y, R, 3'd1, 2, 1'b0);
      after_hw_yellow(1'b1);
      hw_green(4);
`else
      hold(8, G, R, 8'h00, 3'd0, 1'b0);
`endif
      // car held: full cycle twice, reset mid CR_GREEN
      bus.car = 1'b1;
      bus.ped_req = 1'b1;
      hold(1, Y, R, 8'h02, 3'd1, 1'b0);
      bus.ped_req = 1'b0;
      hold(3, Y, R, 8'h02, 3'd1, 1'b0);
      hold(4, Y, R, 8'h01, 3'd1, 1'b0);
      timed(R, R, 3'd2, 1, 1'b0);
      timed(R, G, 3'd3, 4, W);
      timed(R, Y, 3'd4, 2, 1'b0);
      hold(1, R, R, 8'h01, 3'd5, 1'b0);
      bus.ped_req = 1'b1;
      hold(1, R, R, 8'h01, 3'd5, 1'b0);
      bus.ped_req = 1'b0;
      hold(2, R, R, 8'h01, 3'd5, 1'b0);
      hw_green(0);
      timed(Y, R, 3'd1, 2, 1'b0);
      timed(R, R, 3'd2, 1, 1'b0);
      hold(4, R, G, 8'h04, 3'd3, W);
      hold(2, R, G, 8'h03, 3'd3, W);
      @(posedge clk);
      #2;
      rst = 1'b1;
      bus.car = 1'b0;
      q.push_back({G, R, 8'h03, 3'd0, 1'b0});
      @(negedge clk);
      #1;
      rst = 1'b0;
      hold(3, G, R, 8'h03, 3'd0, 1'b0);
      hold(4, G, R, 8'h02, 3'd0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      n_cmp++;
      if (n_cr12 < 12) begin
         n_bad++;
         $display("FAIL cr12_seen: got %0d checks, want >= 12", n_cr12);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
